lsu_split: RTL and testbench
============================

# lsu_split

Load/store unit sitting between the ALU result and the data memory of the RISC-V core. It takes the ALU byte address, `rs2` store data and `funct3`, drives a word-wide data memory with byte enables, and returns sign- or zero-extended load data for write-back. Memory accesses are multi-cycle. The unit stalls the core's PC until the access completes. Misaligned accesses are split into two word accesses in hardware.

## Interface
- `ADDR_W`, default 32: byte-address width; memory word address is `ADDR_W-2` bits.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: current instruction is a load/store; core holds all `req_*` stable while `stall`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other code is illegal.
- `req_addr` in ADDR_W: byte address (ALU result).
- `req_wdata` in 32: store data, right-aligned.
- `stall` out 1: core must not advance PC or write back.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores/errors.
- `err` out 1: valid with `rsp_valid`; illegal funct3 or (macro off) misaligned.
- `mem_req` out 1, `mem_we` out 1, `mem_be` out 4, `mem_addr` out ADDR_W-2, `mem_wdata` out 32: memory request, held stable until `mem_ready`.
- `mem_ready` in 1, `mem_rdata` in 32: access completes in a cycle with `mem_req`&`mem_ready`; `mem_rdata` is valid in that cycle.

## Operation
- FSM states: IDLE, ACC0, ACC1, DONE.
- IDLE: on `req_valid`, latch request; go to ACC0, or to DONE with err set if illegal or (macro off) misaligned. `stall` = `req_valid`.
- ACC0: `mem_req`=1 for word `A`=`addr[ADDR_W-1:2]`. On `mem_ready`, go to ACC1 if a second word is needed, else to DONE.
- ACC1: `mem_req`=1 for word `A+1`, modulo 2^(ADDR_W-2); all-ones wraps to 0. On `mem_ready`, go to DONE.
- DONE: `rsp_valid`=1, `stall`=0, return to IDLE. The core advances at this edge.
- Lane math, with `off`=`addr[1:0]`:
  - 8-bit mask M = 0x1/0x3/0xF for byte/half/word.
  - `be64` = M<<off. `wd64` = `req_wdata`<<(8·off).
  - ACC0 uses the low 32 bits / low 4 be bits; ACC1 uses the high 32 bits / high 4 be bits.
  - ACC1 occurs only if `be64[7:4]`≠0.
- Load assembly: capture `mem_rdata` per access into a 64-bit register (high word 0 if no ACC1). Shift right by 8·off, then sign/zero-extend to 32 bits per funct3. The result is registered and presented in DONE.
- `mem_ready` is ignored outside ACC0/ACC1. `mem_we`=`req_we` latched.
- Reset values (during `rst` and after): state IDLE, `stall`=0, `rsp_valid`=0, `err`=0, `rsp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Aligned access with `mem_ready` tied high: 3 cycles of `stall` (IDLE accept, ACC0, then DONE releasing).
- Split access with `mem_ready` tied high: 4 cycles. Each wait cycle of `mem_ready` low adds 1 cycle.
- Error path: 2 cycles (IDLE, DONE); `mem_req` is never asserted.
- `rst` mid-access (ACC0/ACC1/DONE):
  - At the next edge: return to IDLE, drop `mem_req`, suppress `rsp_valid`.
  - A partially written split store is not rolled back.
- `req_valid` in DONE is the same instruction and is not re-accepted. A new request is accepted only from IDLE.
- Back-to-back load/store instructions: each takes the full sequence; there is no overlap.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Misaligned LH/LHU/SH (off=3) and LW/SW (off≠0) split into two accesses.
  - `err` is only for illegal funct3.
- Not defined:
  - Any misaligned access raises `err` via the 2-cycle error path with no memory activity.
  - ACC1 logic and the high-word capture register are removed.

## Test plan
- LW `addr`=0x100, `mem_rdata`=0xDEADBEEF, ready high -> `mem_addr`=0x40, `mem_be`=0xF, `rsp_rdata`=0xDEADBEEF, `stall` 3 cycles.
- LB `addr`=0x103, `mem_rdata`=0x80123456 -> `mem_be`=0x8, `rsp_rdata`=0xFFFFFF80; LBU same access -> 0x00000080.
- (macro on) SH `addr`=0xFFFFFFFF, `wdata`=0xABCD ->
  - first access: word 0x3FFFFFFF, `be`=0x8, `wdata`=0xCD000000;
  - second access: word 0x0, `be`=0x1, `wdata`=0x000000AB.
- (macro on) LW `addr`=0x102, words 0x11223344 then 0x55667788, `mem_ready` low 2 cycles each access -> `rsp_rdata`=0x77881122, `stall` 8 cycles.
- `rst` pulsed during ACC1 of a split load -> next cycle IDLE, `mem_req`=0, no `rsp_valid`; next request completes normally.
- `req_funct3`=011 load, and (macro off) LW `addr`=0x101 -> `err`=1 with `rsp_valid`, `rsp_rdata`=0, `mem_req` never high, `stall` 2 cycles.

Source files
------------

// File: rtl/lsu_split.sv
// Load/store unit: splits byte-addressed core accesses into word accesses with byte enables.
// Define LSU_MISALIGN_EN to split misaligned accesses in hardware; otherwise they raise err.
module lsu_split #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGN_EN
  localparam int LANES = 8;
`else
  localparam int LANES = 4;
`endif
  localparam int DW = 8 * LANES;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_word;
  logic [LANES-1:0]  r_be;
  logic [DW-1:0]     r_wd;
  logic              r_err;
  logic [31:0]       r_rsp;
`ifdef LSU_MISALIGN_EN
  logic [31:0]       r_lo;
`endif

  logic [1:0]        w_off;
  logic [3:0]        w_mask;
  logic              w_legal;
  logic              w_misal;
  logic [LANES-1:0]  w_be;
  logic [DW-1:0]     w_wd;
  logic [63:0]       w_cap64;
  logic [31:0]       w_aligned;
  logic [31:0]       w_ext;

  assign w_off = req_addr[1:0];

  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_mask = 4'hF;
    case (req_funct3[1:0])
      2'b00:   w_mask = 4'h1;
      2'b01:   w_mask = 4'h3;
      default: w_mask = 4'hF;
    endcase
  end

  // Lane placement; the upper half only exists when splitting is built in.
  assign w_be = LANES'({4'b0000, w_mask} << w_off);
  assign w_wd = DW'({32'h0, req_wdata} << {w_off, 3'b000});

`ifdef LSU_MISALIGN_EN
  assign w_misal = 1'b0;
`else
  assign w_misal = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (w_off != 2'b00));
`endif

`ifdef LSU_MISALIGN_EN
  assign w_cap64 = (r_state == ACC1) ? {mem_rdata, r_lo} : {32'h0, mem_rdata};
`else
  assign w_cap64 = {32'h0, mem_rdata};
`endif
  assign w_aligned = 32'(w_cap64 >> {r_off, 3'b000});

  always_comb begin
    w_ext = 32'h0;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_aligned[7]}}, w_aligned[7:0]};
      3'b001:  w_ext = {{16{w_aligned[15]}}, w_aligned[15:0]};
      3'b010:  w_ext = w_aligned;
      3'b100:  w_ext = {24'h0, w_aligned[7:0]};
      3'b101:  w_ext = {16'h0, w_aligned[15:0]};
      default: w_ext = 32'h0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = (!w_legal || w_misal) ? DONE : ACC0;
`ifdef LSU_MISALIGN_EN
      ACC0: if (mem_ready) w_next = (r_be[7:4] != 4'h0) ? ACC1 : DONE;
      ACC1: if (mem_ready) w_next = DONE;
`else
      ACC0: if (mem_ready) w_next = DONE;
      ACC1: w_next = IDLE;
`endif
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'h0;
    err       = 1'b0;
    mem_req   = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (r_state)
      IDLE: stall = req_valid & ~rst;
      ACC0: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_be    = r_be[3:0];
        mem_addr  = r_word;
        mem_wdata = r_wd[31:0];
      end
`ifdef LSU_MISALIGN_EN
      ACC1: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_be    = r_be[7:4];
        mem_addr  = r_word + {{(ADDR_W-3){1'b0}}, 1'b1};
        mem_wdata = r_wd[63:32];
      end
`endif
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rdata = r_rsp;
        err       = r_err;
      end
      default: ;
    endcase
  end

  assign mem_we = r_we;

  // The result is finalised on the edge that completes the last memory access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_off    <= 2'b00;
      r_word   <= '0;
      r_be     <= '0;
      r_wd     <= '0;
      r_err    <= 1'b0;
      r_rsp    <= 32'h0;
`ifdef LSU_MISALIGN_EN
      r_lo     <= 32'h0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_off    <= w_off;
        r_word   <= req_addr[ADDR_W-1:2];
        r_be     <= w_be;
        r_wd     <= w_wd;
        r_err    <= !w_legal || w_misal;
        r_rsp    <= 32'h0;
      end
`ifdef LSU_MISALIGN_EN
      if (r_state == ACC0 && mem_ready) r_lo <= mem_rdata;
`endif
      if ((r_state == ACC0 || r_state == ACC1) && mem_ready && w_next == DONE)
        r_rsp <= r_we ? 32'h0 : w_ext;
    end
  end

endmodule

// File: tb/tb_lsu_split.sv
// Directed testbench for lsu_split; expectations adapt to LSU_MISALIGN_EN.
module tb_lsu_split;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checkCount = 0;
  int passCount  = 0;

  int          obsCycles;
  int          obsStallHigh;
  int          obsNAcc;
  logic        obsSawReq;
  logic        obsDone;
  logic        obsErr;
  logic        obsWe;
  logic [31:0] obsRdata;
  logic [29:0] obsAddr [2];
  logic [3:0]  obsBe   [2];
  logic [31:0] obsWd   [2];

  lsu_split #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives one instruction and plays a memory that answers after 'waits' idle cycles.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] d0,
                               input logic [31:0] d1, input int waits);
    int waitCnt = 0;
    obsCycles = 0; obsStallHigh = 0; obsNAcc = 0;
    obsSawReq = 1'b0; obsDone = 1'b0; obsErr = 1'b0; obsWe = 1'b0; obsRdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      obsAddr[k] = '0; obsBe[k] = '0; obsWd[k] = '0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ready = (waits == 0);
    for (int i = 0; i < 40 && !obsDone; i++) begin
      #1;
      obsCycles++;
      if (stall) obsStallHigh++;
      if (rsp_valid) begin
        obsDone  = 1'b1;
        obsErr   = err;
        obsRdata = rsp_rdata;
      end else begin
        if (mem_req) begin
          obsSawReq = 1'b1;
          if (waitCnt < waits) begin
            mem_ready = 1'b0;
            waitCnt++;
          end else begin
            mem_ready = 1'b1;
            waitCnt   = 0;
            mem_rdata = (obsNAcc == 0) ? d0 : d1;
            if (obsNAcc < 2) begin
              obsAddr[obsNAcc] = mem_addr;
              obsBe[obsNAcc]   = mem_be;
              obsWd[obsNAcc]   = mem_wdata;
            end
            obsWe = mem_we;
            obsNAcc++;
          end
        end else begin
          mem_ready = (waits == 0);
        end
        @(negedge clk);
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    if (!obsDone) checkOutput("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h0; mem_ready = 1'b1; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_rspv", rsp_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rsp_rdata, 0);
    checkOutput("rst_memreq", mem_req, 0);
    checkOutput("rst_memwe", mem_we, 0);
    checkOutput("rst_membe", mem_be, 0);
    checkOutput("rst_memaddr", mem_addr, 0);
    checkOutput("rst_memwd", mem_wdata, 0);
    req_valid = 1'b0;
    rst = 1'b0;

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0);
    checkOutput("lw_addr", obsAddr[0], 30'h40);
    checkOutput("lw_be", obsBe[0], 4'hF);
    checkOutput("lw_we", obsWe, 0);
    checkOutput("lw_rdata", obsRdata, 32'hDEADBEEF);
    checkOutput("lw_err", obsErr, 0);
    checkOutput("lw_cycles", obsCycles, 3);
    checkOutput("lw_stall", obsStallHigh, 2);
    checkOutput("lw_nacc", obsNAcc, 1);

    applyStimulus(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    checkOutput("lb_be", obsBe[0], 4'h8);
    checkOutput("lb_rdata", obsRdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h0, 0);
    checkOutput("lbu_rdata", obsRdata, 32'h00000080);

    applyStimulus(1'b0, 3'b001, 32'h102, 32'h0, 32'h80123456, 32'h0, 0);
    checkOutput("lh_be", obsBe[0], 4'hC);
    checkOutput("lh_rdata", obsRdata, 32'hFFFF8012);
    applyStimulus(1'b0, 3'b101, 32'h106, 32'h0, 32'hCAFE1234, 32'h0, 0);
    checkOutput("lhu_addr", obsAddr[0], 30'h41);
    checkOutput("lhu_rdata", obsRdata, 32'h0000CAFE);

    applyStimulus(1'b1, 3'b010, 32'h200, 32'h12345678, 32'hFFFFFFFF, 32'h0, 1);
    checkOutput("sw_addr", obsAddr[0], 30'h80);
    checkOutput("sw_be", obsBe[0], 4'hF);
    checkOutput("sw_wd", obsWd[0], 32'h12345678);
    checkOutput("sw_we", obsWe, 1);
    checkOutput("sw_rdata", obsRdata, 0);
    checkOutput("sw_cycles", obsCycles, 4);

    applyStimulus(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 32'h0, 0);
    checkOutput("sb_be", obsBe[0], 4'h2);
    checkOutput("sb_wd", obsWd[0], 32'h0000A500);

    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 32'h12345678, 32'h0, 0);
    checkOutput("ill_err", obsErr, 1);
    checkOutput("ill_rdata", obsRdata, 0);
    checkOutput("ill_memreq", obsSawReq, 0);
    checkOutput("ill_cycles", obsCycles, 2);
    checkOutput("ill_stall", obsStallHigh, 1);
    applyStimulus(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 32'h0, 0);
    checkOutput("ills_err", obsErr, 1);
    checkOutput("ills_memreq", obsSawReq, 0);

`ifdef LSU_MISALIGN_EN
    applyStimulus(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000ABCD, 32'h0, 32'h0, 0);
    checkOutput("sh_a0", obsAddr[0], 30'h3FFFFFFF);
    checkOutput("sh_be0", obsBe[0], 4'h8);
    checkOutput("sh_wd0", obsWd[0], 32'hCD000000);
    checkOutput("sh_a1", obsAddr[1], 30'h0);
    checkOutput("sh_be1", obsBe[1], 4'h1);
    checkOutput("sh_wd1", obsWd[1], 32'h000000AB);
    checkOutput("sh_cycles", obsCycles, 4);
    checkOutput("sh_err", obsErr, 0);

    applyStimulus(1'b0, 3'b010, 32'h102, 32'h0, 32'h11223344, 32'h55667788, 2);
    checkOutput("lwm_be0", obsBe[0], 4'hC);
    checkOutput("lwm_be1", obsBe[1], 4'h3);
    checkOutput("lwm_a1", obsAddr[1], 30'h41);
    checkOutput("lwm_rdata", obsRdata, 32'h77881122);
    checkOutput("lwm_cycles", obsCycles, 8);
    checkOutput("lwm_nacc", obsNAcc, 2);

    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 32'h00ABCD00, 32'h0, 0);
    checkOutput("lh1_rdata", obsRdata, 32'hFFFFABCD);
    checkOutput("lh1_nacc", obsNAcc, 1);
`else
    applyStimulus(1'b0, 3'b010, 32'h101, 32'h0, 32'h12345678, 32'h0, 0);
    checkOutput("mis_err", obsErr, 1);
    checkOutput("mis_rdata", obsRdata, 0);
    checkOutput("mis_memreq", obsSawReq, 0);
    checkOutput("mis_cycles", obsCycles, 2);
    applyStimulus(1'b1, 3'b001, 32'h103, 32'hABCD, 32'h0, 32'h0, 0);
    checkOutput("missh_err", obsErr, 1);
    checkOutput("missh_memreq", obsSawReq, 0);
`endif

    // Reset in the middle of an access must abandon it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; mem_rdata = 32'h11111111;
`ifdef LSU_MISALIGN_EN
    req_addr = 32'h102; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("racc_memreq", mem_req, 1);
    checkOutput("racc_addr", mem_addr, 30'h41);
`else
    req_addr = 32'h100; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("racc_memreq", mem_req, 1);
`endif
    rst = 1'b1; req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("rmid_memreq", mem_req, 0);
    checkOutput("rmid_rspv", rsp_valid, 0);
    checkOutput("rmid_stall", stall, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rpost_rspv", rsp_valid, 0);
    checkOutput("rpost_memreq", mem_req, 0);

    applyStimulus(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADF00D, 32'h0, 0);
    checkOutput("after_rdata", obsRdata, 32'h0BADF00D);
    checkOutput("after_cycles", obsCycles, 3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
